ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline register that feeds the memory stage.
- Latches execute-stage results and control each clock.
- Turns a two-word operation into two consecutive single-word memory beats; used for 32-bit stack pushes/pops such as CALL/RET/INT PC save/restore.
- Stalls upstream during the second beat and supports a flush bubble.

Parameters:
DATA_W, 16, data/ALU word width
ADDR_W, 16, memory address width
REG_W, 3, destination register index width

Ports:
clk  input  1  clock (rising edge)
reset  input  1  synchronous, active-high reset
flush  input  1  replace the next captured instruction with a bubble
ex_valid  input  1  execute stage holds a real instruction
ex_double  input  1  instruction is a two-beat (32-bit) memory op
ex_mem_read  input  1  load/pop
ex_mem_write  input  1  store/push
ex_stack_op  input  1  access uses SP
ex_push_pop  input  1  1 = push, 0 = pop
ex_mem_to_reg  input  1  writeback selects memory data
ex_reg_write  input  1  writeback enable
ex_dest  input  REG_W  destination register
ex_alu_data  input  DATA_W  ALU result
ex_read_add  input  ADDR_W  memory address (non-stack)
ex_write_data  input  DATA_W  store data / low word
ex_write_data_hi  input  DATA_W  high word for two-beat ops
busy  output  1  upstream must hold its outputs this cycle
valid  output  1  memory-stage slot holds a real instruction
beat  output  1  0 = first or only beat, 1 = second beat
mem_read, mem_write, stackOp, pushPop, mem_to_reg, reg_write  output  1 each  registered control to the memory stage
dest  output  REG_W  registered destination
alu_data  output  DATA_W  registered ALU result
read_add  output  ADDR_W  registered address
write_data  output  DATA_W  registered store data for the current beat

Behaviour:
- All outputs are registered.
- Reset (reset = 1 at an edge) has priority over everything:
  - all outputs go to 0;
  - state goes to S_LOAD;
  - the pending-flush flag is cleared.
  - Reset in S_BEAT2 abandons the second beat.
- State S_LOAD (busy = 0). Capture at every edge:
  - flush = 1 or ex_valid = 0: insert a bubble. valid, all control outputs and beat go to 0. Data outputs may hold their previous values.
  - Normal single-beat op: every ex_* field is copied to its output; beat = 0.
  - ex_double = 1:
    - stack push: beat 0 write_data = ex_write_data_hi.
    - otherwise: beat 0 write_data = ex_write_data.
    - beat = 0 and busy goes to 1 at the same edge; next state is S_BEAT2.
- State S_BEAT2 (busy = 1). At the next edge:
  - beat = 1.
  - stack push: write_data = ex_write_data (low word).
  - non-stack: read_add = read_add + 1, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000; write_data = ex_write_data_hi.
  - Stack pops keep read_add unchanged; SP sequencing belongs to the memory stage.
  - All other outputs are unchanged; busy goes to 0; next state is S_LOAD.
- ex_* inputs are ignored while busy = 1. Upstream holds the next instruction, which is captured at the edge where S_BEAT2 completes... no: it is captured at the first S_LOAD edge after that.
- flush during S_BEAT2:
  - The in-flight second beat still completes; stack ops are atomic.
  - The pending-flush flag is set.
  - The next S_LOAD capture is forced to a bubble, then the flag clears.
- ex_mem_read and ex_mem_write both 1 is illegal. The block passes both through unchanged and does not check for it.
- Latency: one cycle from execute to memory-stage inputs. A two-beat op occupies two cycles and inserts one upstream stall cycle.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- When defined, adds the outputs fwd_valid (1), fwd_dest (REG_W) and fwd_data (DATA_W) for EX-stage forwarding:
  - fwd_valid = valid & reg_write & ~mem_to_reg (load data is not yet available);
  - fwd_dest = dest;
  - fwd_data = alu_data.
  - These are combinational from the registered outputs.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: pulse reset with garbage on all ex_* inputs -> next cycle all outputs = 0, busy = 0.
- Single op: ex_valid = 1, ex_mem_write = 1, ex_read_add = 0x0040, ex_write_data = 0x1234, ex_dest = 3 -> one cycle later mem_write = 1, read_add = 0x0040, write_data = 0x1234, valid = 1, beat = 0, busy = 0.
- Two-beat push: ex_double = 1, ex_stack_op = 1, ex_push_pop = 1, ex_mem_write = 1, hi = 0xAAAA, lo = 0x5555 ->
  - cycle 1: write_data = 0xAAAA, beat = 0, busy = 1;
  - cycle 2: write_data = 0x5555, beat = 1, busy = 0;
  - cycle 3: the held next instruction appears.
- Two-beat load at 0xFFFF (non-stack) -> read_add 0xFFFF then 0x0000, beat 0 then 1.
- Flush: flush = 1 with a valid op in S_LOAD -> bubble (valid = 0, mem_write = 0). flush = 1 during S_BEAT2 -> beat 1 still issued, and the following captured op becomes a bubble.
- Reset mid-op: reset = 1 while in S_BEAT2 -> all outputs 0, busy = 0, no beat 1 issued.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register.
// Latches execute results and control every clock. A two-word (32-bit)
// operation is split into two consecutive single-word memory beats, and the
// upstream stage is stalled (busy) while the second beat is issued.
// A flush bubble can be inserted, including one deferred past a second beat.
//
// Optional feature: define EX_MEM_FWD_EN to add fwd_valid/fwd_dest/fwd_data,
// combinational EX-stage forwarding taps derived from the registered outputs.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   flush              turn the next capture into a bubble
//   ex_*               execute-stage instruction fields and control
//   busy               upstream must hold its outputs this cycle
//   valid, beat        slot holds a real op; 0 = first/only beat, 1 = second
//   mem_read .. reg_write, dest, alu_data, read_add, write_data
//                      registered fields for the memory stage
module ex_mem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_double,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_stack_op,
  input  logic              ex_push_pop,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic [DATA_W-1:0] ex_alu_data,
  input  logic [ADDR_W-1:0] ex_read_add,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [DATA_W-1:0] ex_write_data_hi,
  output logic              busy,
  output logic              valid,
  output logic              beat,
  output logic              mem_read,
  output logic              mem_write,
  output logic              stackOp,
  output logic              pushPop,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] alu_data,
  output logic [ADDR_W-1:0] read_add,
  output logic [DATA_W-1:0] write_data
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic {S_LOAD = 1'b0, S_BEAT2 = 1'b1} state_e;

  state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              beat_q, beat_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              stack_op_q, stack_op_d;
  logic              push_pop_q, push_pop_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic [ADDR_W-1:0] read_add_q, read_add_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  // Word for the second beat, saved at capture since upstream moves on.
  logic [DATA_W-1:0] beat2_data_q, beat2_data_d;
  // Flush seen during a second beat, applied to the next capture.
  logic              flush_pend_q, flush_pend_d;

  logic bubble;
  logic push_op;

  assign bubble  = flush | ~ex_valid | flush_pend_q;
  assign push_op = ex_stack_op & ex_push_pop;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      beat_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      stack_op_q   <= 1'b0;
      push_pop_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      dest_q       <= '0;
      alu_data_q   <= '0;
      read_add_q   <= '0;
      write_data_q <= '0;
      beat2_data_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      stack_op_q   <= stack_op_d;
      push_pop_q   <= push_pop_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      dest_q       <= dest_d;
      alu_data_q   <= alu_data_d;
      read_add_q   <= read_add_d;
      write_data_q <= write_data_d;
      beat2_data_q <= beat2_data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (!bubble && ex_double) state_d = S_BEAT2;
      S_BEAT2: state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_d       = busy_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    stack_op_d   = stack_op_q;
    push_pop_d   = push_pop_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    dest_d       = dest_q;
    alu_data_d   = alu_data_q;
    read_add_d   = read_add_q;
    write_data_d = write_data_q;
    beat2_data_d = beat2_data_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      S_LOAD: begin
        busy_d       = 1'b0;
        beat_d       = 1'b0;
        flush_pend_d = 1'b0;
        if (bubble) begin
          // Data fields hold; only validity and control are cleared.
          valid_d      = 1'b0;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          stack_op_d   = 1'b0;
          push_pop_d   = 1'b0;
          mem_to_reg_d = 1'b0;
          reg_write_d  = 1'b0;
        end else begin
          valid_d      = 1'b1;
          mem_read_d   = ex_mem_read;
          mem_write_d  = ex_mem_write;
          stack_op_d   = ex_stack_op;
          push_pop_d   = ex_push_pop;
          mem_to_reg_d = ex_mem_to_reg;
          reg_write_d  = ex_reg_write;
          dest_d       = ex_dest;
          alu_data_d   = ex_alu_data;
          read_add_d   = ex_read_add;
          busy_d       = ex_double;
          // Pushes store the high word first; everything else low first.
          write_data_d = (ex_double && push_op) ? ex_write_data_hi : ex_write_data;
          beat2_data_d = push_op ? ex_write_data : ex_write_data_hi;
        end
      end
      S_BEAT2: begin
        beat_d       = 1'b1;
        busy_d       = 1'b0;
        write_data_d = beat2_data_q;
        // Stack beats leave SP sequencing to the memory stage.
        if (!stack_op_q) read_add_d = read_add_q + ADDR_W'(1);
        if (flush) flush_pend_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign beat       = beat_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign stackOp    = stack_op_q;
  assign pushPop    = push_pop_q;
  assign mem_to_reg = mem_to_reg_q;
  assign reg_write  = reg_write_q;
  assign dest       = dest_q;
  assign alu_data   = alu_data_q;
  assign read_add   = read_add_q;
  assign write_data = write_data_q;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their data arrives only in the memory stage.
  assign fwd_valid = valid_q & reg_write_q & ~mem_to_reg_q;
  assign fwd_dest  = dest_q;
  assign fwd_data  = alu_data_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid, ex_double, ex_mem_read, ex_mem_write;
  logic        ex_stack_op, ex_push_pop, ex_mem_to_reg, ex_reg_write;
  logic [2:0]  ex_dest;
  logic [15:0] ex_alu_data, ex_read_add, ex_write_data, ex_write_data_hi;
  logic        busy, valid, beat, mem_read, mem_write, stackOp, pushPop;
  logic        mem_to_reg, reg_write;
  logic [2:0]  dest;
  logic [15:0] alu_data, read_add, write_data;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_dest;
  logic [15:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid),
    .ex_double(ex_double), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_stack_op(ex_stack_op), .ex_push_pop(ex_push_pop),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_dest(ex_dest), .ex_alu_data(ex_alu_data), .ex_read_add(ex_read_add),
    .ex_write_data(ex_write_data), .ex_write_data_hi(ex_write_data_hi),
    .busy(busy), .valid(valid), .beat(beat), .mem_read(mem_read),
    .mem_write(mem_write), .stackOp(stackOp), .pushPop(pushPop),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .dest(dest),
    .alu_data(alu_data), .read_add(read_add), .write_data(write_data)
`ifdef EX_MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
  );

  // Advance one edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_double = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_stack_op = 1'b0;
    ex_push_pop = 1'b0; ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0;
    ex_dest = '0; ex_alu_data = '0; ex_read_add = '0;
    ex_write_data = '0; ex_write_data_hi = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; ex_valid = 1'b1; ex_double = 1'b1;
    ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_stack_op = 1'b1;
    ex_push_pop = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    ex_dest = 3'h7; ex_alu_data = 16'hDEAD; ex_read_add = 16'hBEEF;
    ex_write_data = 16'hF00D; ex_write_data_hi = 16'hCAFE;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if ({valid, beat, mem_read, mem_write, stackOp, pushPop, mem_to_reg, reg_write} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got=%b want=00000000",
        {valid, beat, mem_read, mem_write, stackOp, pushPop, mem_to_reg, reg_write}); end
    checks++; if ({dest, alu_data, read_add, write_data} !== 51'h0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {dest, alu_data, read_add, write_data}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_read_add = 16'h0040;
    ex_write_data = 16'h1234; ex_dest = 3'd3; ex_alu_data = 16'h0042;
    tick();
    checks++; if ({valid, mem_write, mem_read, beat, busy} !== 5'b11000) begin
      errors++; $display("FAIL single_ctrl got=%b want=11000", {valid, mem_write, mem_read, beat, busy}); end
    checks++; if (read_add !== 16'h0040) begin errors++; $display("FAIL single_addr got=%h want=0040", read_add); end
    checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL single_wdata got=%h want=1234", write_data); end
    checks++; if (dest !== 3'd3 || alu_data !== 16'h0042) begin
      errors++; $display("FAIL single_dest got=%0d/%h want=3/0042", dest, alu_data); end
    idle_inputs();
    tick();
    checks++; if (valid !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL idle_bubble got=%b%b want=00", valid, mem_write); end
  endtask

  task automatic test_push();
    ex_valid = 1'b1; ex_double = 1'b1; ex_stack_op = 1'b1; ex_push_pop = 1'b1;
    ex_mem_write = 1'b1; ex_read_add = 16'h0200;
    ex_write_data_hi = 16'hAAAA; ex_write_data = 16'h5555;
    tick();
    checks++; if (write_data !== 16'hAAAA || beat !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL push_b0 got=%h/%b/%b want=aaaa/0/1", write_data, beat, busy); end
    // Upstream now presents the next instruction; it must be ignored this cycle.
    idle_inputs();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    ex_dest = 3'd5; ex_alu_data = 16'h7777; ex_read_add = 16'h0100;
    ex_write_data = 16'h1111; ex_write_data_hi = 16'h2222;
    tick();
    checks++; if (write_data !== 16'h5555 || beat !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL push_b1 got=%h/%b/%b want=5555/1/0", write_data, beat, busy); end
    checks++; if (read_add !== 16'h0200 || mem_write !== 1'b1 || mem_read !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("FAIL push_b1_hold got=%h/%b%b%b want=0200/101", read_add, mem_write, mem_read, valid); end
    tick();
    checks++; if ({valid, mem_read, mem_write, beat, busy} !== 5'b11000 || read_add !== 16'h0100 || dest !== 3'd5) begin
      errors++; $display("FAIL push_next got=%b/%h/%0d want=11000/0100/5",
        {valid, mem_read, mem_write, beat, busy}, read_add, dest); end
`ifdef EX_MEM_FWD_EN
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_load got=%b want=0", fwd_valid); end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_load_wrap();
    ex_valid = 1'b1; ex_double = 1'b1; ex_mem_read = 1'b1; ex_read_add = 16'hFFFF;
    ex_write_data = 16'hCAFE; ex_write_data_hi = 16'hBEEF;
    tick();
    checks++; if (read_add !== 16'hFFFF || beat !== 1'b0 || busy !== 1'b1 || write_data !== 16'hCAFE) begin
      errors++; $display("FAIL wrap_b0 got=%h/%b/%b/%h want=ffff/0/1/cafe", read_add, beat, busy, write_data); end
    idle_inputs();
    tick();
    checks++; if (read_add !== 16'h0000 || beat !== 1'b1 || write_data !== 16'hBEEF || mem_read !== 1'b1) begin
      errors++; $display("FAIL wrap_b1 got=%h/%b/%h/%b want=0000/1/beef/1", read_add, beat, write_data, mem_read); end
    tick();
    checks++; if (valid !== 1'b0 || beat !== 1'b0) begin
      errors++; $display("FAIL wrap_after got=%b%b want=00", valid, beat); end
  endtask

  task automatic test_flush();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_reg_write = 1'b1; flush = 1'b1;
    ex_read_add = 16'h0300; ex_alu_data = 16'h0055; ex_dest = 3'd2;
    tick();
    checks++; if ({valid, mem_write, reg_write, beat, busy} !== 5'b00000) begin
      errors++; $display("FAIL flush_load got=%b want=00000", {valid, mem_write, reg_write, beat, busy}); end
    flush = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || mem_write !== 1'b1 || read_add !== 16'h0300) begin
      errors++; $display("FAIL flush_recover got=%b%b/%h want=11/0300", valid, mem_write, read_add); end
`ifdef EX_MEM_FWD_EN
    checks++; if (fwd_valid !== 1'b1 || fwd_dest !== 3'd2 || fwd_data !== 16'h0055) begin
      errors++; $display("FAIL fwd_alu got=%b/%0d/%h want=1/2/0055", fwd_valid, fwd_dest, fwd_data); end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_beat2();
    ex_valid = 1'b1; ex_double = 1'b1; ex_mem_write = 1'b1; ex_read_add = 16'h0010;
    ex_write_data = 16'h0001; ex_write_data_hi = 16'h0002;
    tick();
    // Flush lands during the second beat while the next op is held.
    idle_inputs();
    flush = 1'b1; ex_valid = 1'b1; ex_reg_write = 1'b1; ex_dest = 3'd6; ex_alu_data = 16'h0666;
    tick();
    checks++; if (beat !== 1'b1 || valid !== 1'b1 || read_add !== 16'h0011 || write_data !== 16'h0002) begin
      errors++; $display("FAIL fb2_beat1 got=%b%b/%h/%h want=11/0011/0002", beat, valid, read_add, write_data); end
    flush = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || reg_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fb2_bubble got=%b%b%b want=000", valid, reg_write, busy); end
    tick();
    checks++; if (valid !== 1'b1 || reg_write !== 1'b1 || dest !== 3'd6) begin
      errors++; $display("FAIL fb2_clear got=%b%b/%0d want=11/6", valid, reg_write, dest); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_double = 1'b1; ex_stack_op = 1'b1; ex_mem_read = 1'b1;
    ex_read_add = 16'h0500; ex_write_data_hi = 16'h9999;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b want=1", busy); end
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if ({valid, beat, busy, mem_read, stackOp} !== 5'b00000 || read_add !== 16'h0000 || write_data !== 16'h0000) begin
      errors++; $display("FAIL rmid_clear got=%b/%h/%h want=00000/0000/0000",
        {valid, beat, busy, mem_read, stackOp}, read_add, write_data); end
    reset = 1'b0;
    tick();
    checks++; if (beat !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_nobeat got=%b%b%b want=000", beat, valid, busy); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_push();
    test_load_wrap();
    test_flush();
    test_flush_beat2();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
